// File: rtl/freq_meter_pkg.sv
// Shared constants for the frequency meter: nominal divider periods and FSM encoding.
package freq_meter_pkg;

  localparam int PERIOD_M0 = 25_000_000;
  localparam int PERIOD_M1 = 16_666_666;
  localparam int PERIOD_M2 = 12_500_000;
  localparam int PERIOD_M3 = 10_000_000;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic edge_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sig_i};
      prev_q <= sync_q[1];
    end
  end

  assign edge_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Measures the period of sig_in in clk cycles and classifies it against four nominal periods.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int P0      = PERIOD_M0,
  parameter int P1      = PERIOD_M1,
  parameter int P2      = PERIOD_M2,
  parameter int P3      = PERIOD_M3,
  parameter int TOL     = 1000,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic [1:0]       mode,
  output logic             mode_match,
  output logic             locked,
  output logic             no_signal
);

  localparam logic [3:0][WIDTH-1:0] NOM = {WIDTH'(P3), WIDTH'(P2), WIDTH'(P1), WIDTH'(P0)};
  localparam logic [WIDTH-1:0] TOL_W     = WIDTH'(TOL);
  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

  logic edge_pulse;

  sync_edge u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (sig_in),
    .edge_o (edge_pulse)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic [1:0]       mode_q, mode_d;
  logic             match_q, match_d;
  logic             locked_q, locked_d;
  logic             nosig_q, nosig_d;

  logic             hit;
  logic [1:0]       hit_idx;

  function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Scanning from the highest index down leaves the lowest matching index in hit_idx.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (abs_diff(cnt_q, NOM[i]) <= TOL_W) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    mode_d   = mode_q;
    match_d  = match_q;
    locked_d = locked_q;
    nosig_d  = nosig_q;

    unique case (state_q)
      IDLE: begin
        if (edge_pulse) begin
          cnt_d   = WIDTH'(1);
          state_d = MEASURE;
          nosig_d = 1'b0;
        end
      end
      MEASURE: begin
        if (edge_pulse) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
          cnt_d    = WIDTH'(1);
          if (hit) begin
            mode_d   = hit_idx;
            match_d  = 1'b1;
            // match_q/mode_q still describe the previous measurement here.
            locked_d = match_q && (mode_q == hit_idx);
          end else begin
            match_d  = 1'b0;
            locked_d = 1'b0;
          end
        end else if (cnt_q == TIMEOUT_W) begin
          state_d  = IDLE;
          nosig_d  = 1'b1;
          locked_d = 1'b0;
          match_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      mode_q   <= 2'd0;
      match_q  <= 1'b0;
      locked_q <= 1'b0;
      nosig_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      mode_q   <= mode_d;
      match_q  <= match_d;
      locked_q <= locked_d;
      nosig_q  <= nosig_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign mode         = mode_q;
  assign mode_match   = match_q;
  assign locked       = locked_q;
  assign no_signal    = nosig_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: directed table, hand-written corner sequences, random periods.
module tb_freq_meter;

  localparam int WIDTH   = 16;
  localparam int P0      = 100;
  localparam int P1      = 66;
  localparam int P2      = 50;
  localparam int P3      = 40;
  localparam int TOL     = 2;
  localparam int TIMEOUT = 300;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sig_in = 1'b0;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic [1:0]       mode;
  logic             mode_match;
  logic             locked;
  logic             no_signal;

  freq_meter #(
    .WIDTH(WIDTH), .P0(P0), .P1(P1), .P2(P2), .P3(P3), .TOL(TOL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sig_in       (sig_in),
    .period       (period),
    .period_valid (period_valid),
    .mode         (mode),
    .mode_match   (mode_match),
    .locked       (locked),
    .no_signal    (no_signal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d", name, act, act, exp);
    end
  endtask

  // Reference model: tracks rise-to-rise intervals and applies the classification rules directly.
  int nom [4] = '{P0, P1, P2, P3};
  bit m_armed, m_valid, m_match, m_locked, m_nosig;
  int m_since, m_period, m_mode, m_prev_idx;

  function automatic int classify(input int c);
    for (int i = 0; i < 4; i++) begin
      int d = c - nom[i];
      if (d < 0) d = -d;
      if (d <= TOL) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_armed = 0; m_valid = 0; m_match = 0; m_locked = 0; m_nosig = 1;
    m_since = 0; m_period = 0; m_mode = 0; m_prev_idx = -1;
  endtask

  task automatic model_timeout();
    m_armed = 0; m_nosig = 1; m_locked = 0; m_match = 0; m_prev_idx = -1;
  endtask

  task automatic model_rise();
    int idx;
    m_valid = 0;
    if (m_armed && m_since > TIMEOUT) model_timeout();
    if (!m_armed) begin
      m_armed = 1;
      m_nosig = 0;
    end else begin
      m_valid  = 1;
      m_period = m_since;
      idx      = classify(m_since);
      if (idx >= 0) begin
        m_locked   = (m_prev_idx == idx);
        m_mode     = idx;
        m_match    = 1;
        m_prev_idx = idx;
      end else begin
        m_locked   = 0;
        m_match    = 0;
        m_prev_idx = -1;
      end
    end
  endtask

  typedef struct {
    int p;
    bit valid;
    int period;
    int mode;
    bit match;
    bit locked;
  } vec_t;

  // One rising edge followed by p-1 further cycles; outputs for this edge are sampled 3 negedges later.
  task automatic pulse(input int p, input bit use_tbl, input vec_t v);
    bit e_valid, e_match, e_locked;
    int e_period, e_mode;
    model_rise();
    e_valid  = use_tbl ? v.valid  : m_valid;
    e_period = use_tbl ? v.period : m_period;
    e_mode   = use_tbl ? v.mode   : m_mode;
    e_match  = use_tbl ? v.match  : m_match;
    e_locked = use_tbl ? v.locked : m_locked;
    sig_in  = 1'b1;
    m_since = 0;
    for (int i = 1; i <= p; i++) begin
      @(negedge clk);
      m_since++;
      sig_in = (i < p / 2);
      if (i == 2) check("valid_early", 32'(period_valid), 0);
      if (i == 3) begin
        check("valid", 32'(period_valid), 32'(e_valid));
        check("period", 32'(period), 32'(e_period));
        check("mode", 32'(mode), 32'(e_mode));
        check("mode_match", 32'(mode_match), 32'(e_match));
        check("locked", 32'(locked), 32'(e_locked));
        check("no_signal", 32'(no_signal), 0);
      end
      if (i == 4) check("valid_width", 32'(period_valid), 0);
    end
  endtask

  task automatic idle(input int n);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      m_since++;
      sig_in = 1'b0;
      if (period_valid) pulses++;
      if (m_armed && m_since == TIMEOUT + 2) begin
        check("pre_timeout_no_signal", 32'(no_signal), 0);
        check("pre_timeout_locked", 32'(locked), 32'(m_locked));
      end
      if (m_armed && m_since == TIMEOUT + 3) begin
        model_timeout();
        check("timeout_no_signal", 32'(no_signal), 1);
        check("timeout_locked", 32'(locked), 0);
        check("timeout_match", 32'(mode_match), 0);
        check("timeout_period_hold", 32'(period), 32'(m_period));
        check("timeout_mode_hold", 32'(mode), 32'(m_mode));
      end
    end
    check("idle_no_valid", 32'(pulses), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_period"}, 32'(period), 0);
    check({tag, "_valid"}, 32'(period_valid), 0);
    check({tag, "_mode"}, 32'(mode), 0);
    check({tag, "_match"}, 32'(mode_match), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_no_signal"}, 32'(no_signal), 1);
  endtask

  task automatic mid_reset();
    #3;
    rst_n  = 1'b0;
    sig_in = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs [17];
  vec_t none;

  initial begin
    none = '{0, 0, 0, 0, 0, 0};
    //           p   valid period mode match locked
    vecs[0]  = '{66,  0,    0,    0,   0,    0};
    vecs[1]  = '{66,  1,    66,   1,   1,    0};
    vecs[2]  = '{101, 1,    66,   1,   1,    1};
    vecs[3]  = '{41,  1,    101,  0,   1,    0};
    vecs[4]  = '{41,  1,    41,   3,   1,    0};
    vecs[5]  = '{50,  1,    41,   3,   1,    1};
    vecs[6]  = '{50,  1,    50,   2,   1,    0};
    vecs[7]  = '{80,  1,    50,   2,   1,    1};
    vecs[8]  = '{300, 1,    80,   2,   0,    0};
    vecs[9]  = '{66,  1,    300,  2,   0,    0};
    vecs[10] = '{66,  1,    66,   1,   1,    0};
    vecs[11] = '{98,  1,    66,   1,   1,    1};
    vecs[12] = '{97,  1,    98,   0,   1,    0};
    vecs[13] = '{66,  1,    97,   0,   0,    0};
    vecs[14] = '{66,  1,    66,   1,   1,    0};
    vecs[15] = '{66,  1,    66,   1,   1,    1};
    vecs[16] = '{66,  1,    66,   1,   1,    1};

    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;

    idle(40);
    check_reset_outputs("quiet");

    for (int k = 0; k < 17; k++) pulse(vecs[k].p, 1'b1, vecs[k]);

    // Stop toggling while locked: timeout, then re-arm and measure again.
    check("locked_before_stop", 32'(locked), 1);
    idle(TIMEOUT + 20);
    pulse(66, 1'b0, none);
    check("rearm_no_valid_model", 32'(m_valid), 0);
    pulse(66, 1'b0, none);
    pulse(66, 1'b0, none);

    // Interval one past TIMEOUT must time out instead of measuring.
    pulse(TIMEOUT + 1, 1'b0, none);
    pulse(50, 1'b0, none);
    pulse(50, 1'b0, none);
    pulse(50, 1'b0, none);

    // Asynchronous reset while locked, then a clean restart.
    check("locked_before_reset", 32'(locked), 1);
    mid_reset();
    idle(10);
    pulse(40, 1'b0, none);
    pulse(40, 1'b0, none);
    pulse(40, 1'b0, none);

    for (int k = 0; k < 40; k++) begin
      int r, p;
      r = int'($urandom_range(0, 9));
      if (r < 6)       p = nom[$urandom_range(0, 3)] + int'($urandom_range(0, 6)) - 3;
      else if (r < 8)  p = int'($urandom_range(6, 120));
      else if (r == 8) p = TIMEOUT - 1 + int'($urandom_range(0, 2));
      else begin
        idle(int'($urandom_range(200, 320)));
        p = nom[$urandom_range(0, 3)];
      end
      pulse(p, 1'b0, none);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
